// File: rtl/serial_word_rx_if.sv
// Serial link bundle between a bit-stream source and the word receiver.
// The master drives the strobed line; the slave returns the reassembled word and status.
interface serial_word_rx_if #(
  parameter int unsigned WIDTH = 5
) ();
  logic             si;
  logic             si_valid;
  logic             lsb_first;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             parity_err;
  logic             frame_err;
  logic             busy;

  modport master (
    output si, si_valid, lsb_first,
    input  po, po_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  si, si_valid, lsb_first,
    output po, po_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/serial_word_rx.sv
// Serial word receiver: start, WIDTH data bits, optional even parity, stop.
// Reassembles MSB- or LSB-first words and reports framing/parity errors as one-cycle pulses.
module serial_word_rx #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned PARITY_EN = 1
) (
  input logic             clk,
  input logic             rst,
  serial_word_rx_if.slave link
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             dir_q, dir_d;
  logic             par_q, par_d;
  logic             rxpar_q, rxpar_d;
  logic             po_valid_q, po_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    po_d         = po_q;
    dir_d        = dir_q;
    par_d        = par_q;
    rxpar_d      = rxpar_q;
    po_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    if (link.si_valid) begin
      unique case (state_q)
        StIdle: begin
          if (!link.si) begin
            state_d = StData;
            dir_d   = link.lsb_first;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        StData: begin
          sh_d  = dir_q ? {link.si, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], link.si};
          par_d = par_q ^ link.si;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end
        end
        StParity: begin
          rxpar_d = link.si;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          // A bad stop bit discards the word, so parity is not reported either.
          if (link.si) begin
            po_d         = sh_q;
            po_valid_d   = 1'b1;
            parity_err_d = (PARITY_EN != 0) && (rxpar_q != par_q);
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sh_q         <= '0;
      po_q         <= '0;
      dir_q        <= 1'b0;
      par_q        <= 1'b0;
      rxpar_q      <= 1'b0;
      po_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      po_q         <= po_d;
      dir_q        <= dir_d;
      par_q        <= par_d;
      rxpar_q      <= rxpar_d;
      po_valid_q   <= po_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign link.po         = po_q;
  assign link.po_valid   = po_valid_q;
  assign link.parity_err = parity_err_q;
  assign link.frame_err  = frame_err_q;
  assign link.busy       = (state_q != StIdle);
endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Receive side of the team's serial shift-register link. Consumes a strobed bit stream framed as start, WIDTH data bits, optional parity, stop.
- Reassembles the data bits into a parallel word. Bit order is selectable, matching the left-shift and right-shift modes of the universal shift register.
- Sits between the serial line and downstream parallel logic. Presents each good word with a one-cycle valid pulse and flags framing and parity errors.

Parameters:
- WIDTH, 5, number of data bits per frame (>=2).
- PARITY_EN, 1, 1 = an even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- si  input  1  serial data line; idle level 1.
- si_valid  input  1  bit strobe; si is sampled only in cycles where si_valid=1.
- lsb_first  input  1  0 = MSB first (shift left, new bit into po[0]); 1 = LSB first (shift right, new bit into po[WIDTH-1]). Sampled with the start bit.
- po  output  WIDTH  last good received word.
- po_valid  output  1  one-cycle pulse when po is updated.
- parity_err  output  1  one-cycle pulse, coincident with po_valid, when the parity check fails.
- frame_err  output  1  one-cycle pulse when the stop bit is 0.
- busy  output  1  1 while a frame is in progress (state != IDLE).

Behaviour:
- Reset: rst, synchronous and active-high, dominates all other inputs.
  - Reset values: po=0, po_valid=0, parity_err=0, frame_err=0, busy=0.
  - State returns to IDLE, bit counter clears, shift register clears.
  - Reset mid-frame abandons the frame with no error pulse.
- Cycles with si_valid=0: no state, counter or shift change. Gaps of any length between strobes are legal.
- State IDLE:
  - Strobe with si=0 is the start bit: latch lsb_first into dir, clear counter, go to DATA.
  - Strobe with si=1 stays in IDLE.
- State DATA:
  - Each strobe shifts si into the shift register. dir=0: sh <= {sh[WIDTH-2:0], si}. dir=1: sh <= {si, sh[WIDTH-1:1]}.
  - Each strobe XORs si into the running parity and increments the counter.
  - After the WIDTH-th bit, go to PARITY if PARITY_EN=1, else go to STOP.
- State PARITY: the strobe stores the received parity bit; go to STOP.
- State STOP: the strobe samples the stop bit, then state goes to IDLE.
  - si=1: in the next cycle po <= sh and po_valid=1. parity_err=1 in that same cycle if PARITY_EN=1 and received parity != XOR of the data bits.
  - si=0: in the next cycle frame_err=1, po and po_valid are unchanged, parity is not reported.
- Output pulses are registered and last exactly one cycle.
- po holds its value between frames.
- The earliest next start bit is the strobe immediately after the stop strobe; back-to-back frames lose no bits.
- Strobe timing: si_valid may be high on consecutive cycles. Minimum frame = WIDTH+2+PARITY_EN cycles.
- Changes on lsb_first during a frame have no effect.
- busy is 1 from the cycle after the start strobe until the cycle after the stop strobe.

Test Plan (WIDTH=5, PARITY_EN=1 unless noted):
1. MSB-first good frame: rst for 2 cycles, then check all outputs=0. lsb_first=0; strobe on consecutive cycles 0,1,0,1,1,0,1,1 (start, data 10110, parity 1, stop 1) -> po=5'b10110 with a single po_valid pulse, parity_err=0, busy back to 0.
2. LSB-first same serial bits: lsb_first=1 -> po=5'b01101, po_valid pulse, parity_err=0.
3. Parity error: MSB-first data 10110 with parity bit 0 -> po=5'b10110, po_valid and parity_err both pulse in the same cycle.
4. Framing error plus gaps: si_valid low 3 cycles between each bit; stop bit 0 -> frame_err pulse, po keeps its previous value, no po_valid. A following good frame with data 00001 -> po=5'b00001.
5. Reset mid-frame: assert rst after 3 data bits -> no pulses, busy=0, po=0. A fresh frame with data 11111 and parity 1 -> po=5'b11111.
6. Back-to-back frames, no parity: PARITY_EN=0, frames with data 10000 then 00011 sent with no idle strobes between them -> two po_valid pulses, with po=5'b10000 then po=5'b00011.
